// File: rtl/ui_pkg.sv
// ui_pkg: shared digit widths, converter states and blank-mask reset constant for the score UI.
package ui_pkg;
    localparam int BCD_W = 4;
    localparam int SCORE_DIGITS = 5;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
    localparam logic [SCORE_DIGITS-1:0] LZ_RESET = 5'b11110;
endpackage

// File: rtl/bcd_add3_adjust.sv
// bcd_add3_adjust: double-dabble correction, adds 3 to every BCD digit that is 5 or more.
module bcd_add3_adjust
    import ui_pkg::*;
#(
    parameter int DIGITS = SCORE_DIGITS
) (
    input  logic [BCD_W*DIGITS-1:0] acc,
    output logic [BCD_W*DIGITS-1:0] adj
);
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign adj[BCD_W*g +: BCD_W] = acc[BCD_W*g +: BCD_W] >= 4'd5 ?
                                       acc[BCD_W*g +: BCD_W] + 4'd3 : acc[BCD_W*g +: BCD_W];
    end
endmodule

// File: rtl/score_bcd_converter.sv
// score_bcd_converter: converts the binary score to BCD by iterative double-dabble and
// publishes all digits plus a leading-zero blank mask atomically.
module score_bcd_converter
    import ui_pkg::*;
#(
    parameter int BIN_W = 16,
    parameter int DIGITS = SCORE_DIGITS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [BIN_W-1:0]        score,
    output logic [BCD_W*DIGITS-1:0] bcd_digits,
    output logic [DIGITS-1:0]       lz_blank,
    output logic                    digits_valid,
    output logic                    update_pulse,
    output logic                    busy
);
    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_t state, nxt;
    logic [BIN_W-1:0] last_score, shift_reg;
    logic [BCD_W*DIGITS-1:0] bcd_acc, adj;
    logic [CNT_W-1:0] cnt;
    logic start_pending, trigger, last_shift, zero_run;
    logic [DIGITS-1:0] mask;

    bcd_add3_adjust #(.DIGITS(DIGITS)) u_adjust (.acc(bcd_acc), .adj(adj));

    assign trigger = (score != last_score) || start_pending;
    assign last_shift = cnt == CNT_W'(BIN_W - 1);
    assign busy = state != IDLE;

    always_comb begin
        nxt = state == IDLE  ? (trigger ? SHIFT : IDLE) :
              state == SHIFT ? (last_shift ? DONE : SHIFT) : IDLE;
    end

    // A digit blanks only while it and every digit above it are zero; the ones digit always shows.
    always_comb begin
        mask = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (bcd_acc[BCD_W*i +: BCD_W] == '0);
            mask[i] = zero_run;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_score    <= '0;
            start_pending <= 1'b1;
            shift_reg     <= '0;
            bcd_acc       <= '0;
            cnt           <= '0;
            bcd_digits    <= '0;
            lz_blank      <= LZ_RESET;
            digits_valid  <= 1'b0;
            update_pulse  <= 1'b0;
        end else begin
            update_pulse <= 1'b0;
            case (state)
                IDLE: if (trigger) begin
                    shift_reg     <= score;
                    last_score    <= score;
                    bcd_acc       <= '0;
                    cnt           <= '0;
                    start_pending <= 1'b0;
                end
                SHIFT: begin
                    bcd_acc   <= {adj[BCD_W*DIGITS-2:0], shift_reg[BIN_W-1]};
                    shift_reg <= shift_reg << 1;
                    cnt       <= cnt + 1'b1;
                end
                DONE: begin
                    bcd_digits   <= bcd_acc;
                    lz_blank     <= mask;
                    digits_valid <= 1'b1;
                    update_pulse <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_score_bcd_converter.sv
// tb_score_bcd_converter: randomized and directed checks of the score BCD converter against
// a decimal-arithmetic reference model.
module tb_score_bcd_converter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [15:0] score = '0;
    logic [19:0] bcd_digits;
    logic [4:0] lz_blank;
    logic digits_valid, update_pulse, busy;
    int total = 0;
    int bad = 0;

    score_bcd_converter dut (
        .clk(clk), .reset_n(reset_n), .score(score), .bcd_digits(bcd_digits),
        .lz_blank(lz_blank), .digits_valid(digits_valid), .update_pulse(update_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int p;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_lz(input int v);
        logic [4:0] r;
        int p;
        r = '0;
        p = 10;
        for (int i = 1; i < 5; i++) begin
            r[i] = v < p;
            p *= 10;
        end
        return r;
    endfunction

    // Called at a negedge just before the capture edge; returns at the negedge after the publish.
    task automatic expect_publish(input int v, input string tag, input logic valid_before);
        int n;
        n = 1;
        @(posedge clk); @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_on_capture got %b want 1", tag, busy); end
        total++; if (digits_valid !== valid_before) begin bad++; $display("FAIL %s valid_before got %b want %b", tag, digits_valid, valid_before); end
        while (!update_pulse && n < 40) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        total++; if (n != 18) begin bad++; $display("FAIL %s latency got %0d want 18", tag, n); end
        total++; if (bcd_digits !== ref_bcd(v)) begin bad++; $display("FAIL %s digits got %h want %h", tag, bcd_digits, ref_bcd(v)); end
        total++; if (lz_blank !== ref_lz(v)) begin bad++; $display("FAIL %s lz_blank got %b want %b", tag, lz_blank, ref_lz(v)); end
        total++; if (digits_valid !== 1'b1) begin bad++; $display("FAIL %s valid got %b want 1", tag, digits_valid); end
    endtask

    task automatic convert(input logic [15:0] v, input string tag);
        score = v;
        expect_publish(int'(v), tag, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if (bcd_digits !== 20'h0 || lz_blank !== 5'b11110 || digits_valid !== 1'b0 ||
            update_pulse !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s got digits=%h lz=%b valid=%b pulse=%b busy=%b want 00000 11110 0 0 0",
                     tag, bcd_digits, lz_blank, digits_valid, update_pulse, busy);
        end
    endtask

    task automatic test_reset;
        score = 16'd0;
        @(negedge clk);
        check_reset_values("reset_values");
        reset_n = 1'b1;
        expect_publish(0, "reset_zero", 1'b0);
        @(posedge clk); @(negedge clk);
        total++; if (update_pulse !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_after pulse=%b busy=%b want 0 0", update_pulse, busy); end
    endtask

    task automatic test_stable;
        int seen;
        convert(16'd2048, "score_2048");
        seen = 0;
        repeat (25) begin
            @(posedge clk); @(negedge clk);
            if (update_pulse || busy) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL stable_no_update got %0d active cycles want 0", seen); end
    endtask

    task automatic test_max;
        convert(16'd65535, "score_max");
    endtask

    task automatic test_back_to_back;
        int c, pulses, stray;
        int at[2];
        logic [19:0] got_d[2];
        logic [4:0] got_l[2];
        c = 0; pulses = 0; stray = 0;
        score = 16'd100;
        while (pulses < 2 && c < 80) begin
            @(posedge clk); @(negedge clk);
            c++;
            if (c == 6) score = 16'd4096;
            if (bcd_digits !== 20'h65535 && bcd_digits !== 20'h00100 && bcd_digits !== 20'h04096) stray++;
            if (update_pulse) begin
                at[pulses] = c; got_d[pulses] = bcd_digits; got_l[pulses] = lz_blank;
                pulses++;
            end
        end
        total++; if (pulses != 2) begin bad++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
        else begin
            total++; if (got_d[0] !== 20'h00100 || got_l[0] !== 5'b11000) begin bad++; $display("FAIL b2b_first got %h %b want 00100 11000", got_d[0], got_l[0]); end
            total++; if (got_d[1] !== 20'h04096 || got_l[1] !== 5'b10000) begin bad++; $display("FAIL b2b_second got %h %b want 04096 10000", got_d[1], got_l[1]); end
            total++; if (at[0] != 18 || at[1] != 36) begin bad++; $display("FAIL b2b_timing got %0d,%0d want 18,36", at[0], at[1]); end
        end
        total++; if (stray != 0) begin bad++; $display("FAIL b2b_intermediate got %0d stray cycles want 0", stray); end
    endtask

    task automatic test_reset_mid;
        score = 16'd9999;
        repeat (9) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_values("reset_mid");
        @(negedge clk);
        reset_n = 1'b1;
        expect_publish(9999, "reset_mid_restart", 1'b0);
    endtask

    task automatic test_sweep;
        logic [15:0] edges[14] = '{16'd0, 16'd1, 16'd9, 16'd10, 16'd99, 16'd100, 16'd999,
                                   16'd1000, 16'd9999, 16'd10000, 16'd59999, 16'd60000, 16'd65534, 16'd65535};
        logic [15:0] cur, v;
        cur = score;
        for (int i = 0; i < 14 + 2400; i++) begin
            v = i < 14 ? edges[i] : 16'($urandom);
            if (v == cur) v = v + 16'd1;
            convert(v, $sformatf("sweep_%0d", v));
            cur = v;
        end
    endtask

    initial begin
        test_reset;
        test_stable;
        test_max;
        test_back_to_back;
        test_reset_mid;
        test_sweep;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
